// File: rtl/nn_pkg.sv
// Shared constants for the MLP layer scheduler: FSM encoding and layer-geometry helpers.
// Pure declarations; no logic, no latency, no flow control.
package nn_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLR   = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_RESC  = 3'd4;
    localparam logic [2:0] S_ACT   = 3'd5;
    localparam logic [2:0] S_STORE = 3'd6;
    localparam logic [2:0] S_DONE  = 3'd7;

    function automatic int fan_in(input int layer, input int no_nil, input int no_nhl);
        return (layer == 0) ? no_nil : no_nhl;
    endfunction

    function automatic int fan_out(input int layer, input int no_hl, input int no_nhl, input int no_nol);
        return (layer == no_hl) ? no_nol : no_nhl;
    endfunction

    function automatic int total_weights(input int no_hl, input int no_nil, input int no_nhl,
                                         input int no_nol);
        return no_nil * no_nhl + (no_hl - 1) * no_nhl * no_nhl + no_nhl * no_nol;
    endfunction

    function automatic int calc_waw(input int no_hl, input int no_nil, input int no_nhl,
                                    input int no_nol);
        return $clog2(total_weights(no_hl, no_nil, no_nhl, no_nol));
    endfunction

    function automatic int calc_iaw(input int no_nil, input int no_nhl);
        return $clog2((no_nil > no_nhl) ? no_nil : no_nhl);
    endfunction

endpackage

// File: rtl/layer_sched_if.sv
// Scheduler <-> datapath bundle: start/done handshake, read addresses, strobes, store request.
// Wires only; store_ack is the sole backpressure and stalls the scheduler in its store phase.
interface layer_sched_if #(
    parameter int IAW = 10,
    parameter int WAW = 15
);
    logic           start;
    logic           store_ack;
    logic [IAW-1:0] in_addr;
    logic           in_sel;
    logic [WAW-1:0] w_addr;
    logic           mac_clr;
    logic           mac_en;
    logic           rescale;
    logic           act_en;
    logic           store_en;
    logic [IAW-1:0] store_addr;
    logic           last_layer;
    logic           busy;
    logic           done;

    modport master (
        input  start, store_ack,
        output in_addr, in_sel, w_addr, mac_clr, mac_en, rescale, act_en,
               store_en, store_addr, last_layer, busy, done
    );

    modport slave (
        output start, store_ack,
        input  in_addr, in_sel, w_addr, mac_clr, mac_en, rescale, act_en,
               store_en, store_addr, last_layer, busy, done
    );
endinterface

// File: rtl/sched_counter.sv
// Wrap counter with terminal-count flag; sync clear wins over increment.
// Single-cycle update, no backpressure (increment is the enable).
module sched_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    input  logic [W-1:0] max_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);
    logic [W-1:0] cnt_q, cnt_d;

    assign tc_o  = (cnt_q == max_i);
    assign cnt_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = tc_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/layer_sched.sv
// Walks every neuron of every MLP layer, issuing read addresses, MAC/rescale/act strobes and stores.
// fan_in+RD_LAT+4 cycles per neuron; store_ack low holds the store phase and freezes all counters.
module layer_sched
    import nn_pkg::*;
#(
    parameter int NO_HL  = 2,
    parameter int NO_NIL = 784,
    parameter int NO_NHL = 28,
    parameter int NO_NOL = 10,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    layer_sched_if.master bus
);
    localparam int IAW = calc_iaw(NO_NIL, NO_NHL);
    localparam int WAW = calc_waw(NO_HL, NO_NIL, NO_NHL, NO_NOL);
    localparam int LW  = $clog2(NO_HL + 1);
    localparam logic [1:0] DRAIN_LAST = 2'(RD_LAT - 1);

    logic [2:0]        state_q, state_d;
    logic [1:0]        drain_q, drain_d;
    logic [WAW-1:0]    w_q, w_d;
    logic [RD_LAT-1:0] mac_sh_q, mac_sh_d;

    logic [IAW-1:0] k_cnt, k_max, n_cnt, n_max;
    logic [LW-1:0]  l_cnt;
    logic           k_tc, n_tc, l_tc;
    logic           in_idle, in_fetch, in_store, store_acc;

    assign in_idle   = (state_q == S_IDLE);
    assign in_fetch  = (state_q == S_FETCH);
    assign in_store  = (state_q == S_STORE);
    assign store_acc = in_store && bus.store_ack;

    assign k_max = IAW'(fan_in(int'(l_cnt), NO_NIL, NO_NHL) - 1);
    assign n_max = IAW'(fan_out(int'(l_cnt), NO_HL, NO_NHL, NO_NOL) - 1);

    sched_counter #(.W(IAW)) u_k (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (in_idle || state_q == S_CLR),
        .inc_i (in_fetch),
        .max_i (k_max),
        .cnt_o (k_cnt),
        .tc_o  (k_tc)
    );

    sched_counter #(.W(IAW)) u_n (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (in_idle),
        .inc_i (store_acc),
        .max_i (n_max),
        .cnt_o (n_cnt),
        .tc_o  (n_tc)
    );

    sched_counter #(.W(LW)) u_l (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (in_idle),
        .inc_i (store_acc && n_tc),
        .max_i (LW'(NO_HL)),
        .cnt_o (l_cnt),
        .tc_o  (l_tc)
    );

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_CLR;
            S_CLR:   state_d = S_FETCH;
            S_FETCH: begin
                if (k_tc) begin
                    state_d = S_DRAIN;
                    drain_d = '0;
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) state_d = S_RESC;
                else                       drain_d = drain_q + 1'b1;
            end
            S_RESC:  state_d = S_ACT;
            S_ACT:   state_d = S_STORE;
            S_STORE: if (bus.store_ack) state_d = (n_tc && l_tc) ? S_DONE : S_CLR;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Weight pointer runs contiguously across neurons and layers; only a finished or idle run rewinds it.
    always_comb begin
        w_d = w_q;
        if (in_idle || state_q == S_DONE) w_d = '0;
        else if (in_fetch)                 w_d = w_q + 1'b1;
    end

    assign mac_sh_d = (mac_sh_q << 1) | RD_LAT'(in_fetch);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            drain_q  <= '0;
            w_q      <= '0;
            mac_sh_q <= '0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            w_q      <= w_d;
            mac_sh_q <= mac_sh_d;
        end
    end

    assign bus.in_addr    = k_cnt;
    assign bus.in_sel     = l_cnt[0];
    assign bus.w_addr     = w_q;
    assign bus.mac_clr    = (state_q == S_CLR);
    assign bus.mac_en     = mac_sh_q[RD_LAT-1];
    assign bus.rescale    = (state_q == S_RESC);
    assign bus.act_en     = (state_q == S_ACT);
    assign bus.store_en   = in_store;
    assign bus.store_addr = n_cnt;
    assign bus.last_layer = l_tc;
    assign bus.busy       = !in_idle && (state_q != S_DONE);
    assign bus.done       = (state_q == S_DONE);
endmodule

// File: tb/tb_layer_sched.sv
// Bench for layer_sched: two instances (RD_LAT 1 and 3) on a 4-3-3-2 network, checked cycle by cycle
// against a trace built from the layer/neuron/input schedule, with random ack delays and stray starts.
module tb_layer_sched;
    import nn_pkg::*;

    localparam int NIL = 4;
    localparam int NHL = 3;
    localparam int NOL = 2;
    localparam int HL  = 2;
    localparam int IAW = calc_iaw(NIL, NHL);
    localparam int WAW = calc_waw(HL, NIL, NHL, NOL);

    localparam int P_IDLE = 0, P_CLR = 1, P_FETCH = 2, P_DRAIN = 3;
    localparam int P_RESC = 4, P_ACT = 5, P_STORE = 6, P_DONE = 7;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic start_r = 1'b0;
    logic ack_r   = 1'b0;
    int   sel     = 0;

    always #5 clk = ~clk;

    layer_sched_if #(.IAW(IAW), .WAW(WAW)) if1 ();
    layer_sched_if #(.IAW(IAW), .WAW(WAW)) if3 ();

    assign if1.start     = start_r && (sel == 0);
    assign if1.store_ack = ack_r   && (sel == 0);
    assign if3.start     = start_r && (sel == 1);
    assign if3.store_ack = ack_r   && (sel == 1);

    layer_sched #(.NO_HL(HL), .NO_NIL(NIL), .NO_NHL(NHL), .NO_NOL(NOL), .RD_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1));
    layer_sched #(.NO_HL(HL), .NO_NIL(NIL), .NO_NHL(NHL), .NO_NOL(NOL), .RD_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(if3));

    wire [6:0] o_ctl = (sel == 1) ?
        {if3.busy, if3.done, if3.mac_clr, if3.mac_en, if3.rescale, if3.act_en, if3.store_en} :
        {if1.busy, if1.done, if1.mac_clr, if1.mac_en, if1.rescale, if1.act_en, if1.store_en};
    wire [1:0]     o_lyr = (sel == 1) ? {if3.last_layer, if3.in_sel} : {if1.last_layer, if1.in_sel};
    wire [IAW-1:0] o_ia  = (sel == 1) ? if3.in_addr    : if1.in_addr;
    wire [WAW-1:0] o_wa  = (sel == 1) ? if3.w_addr     : if1.w_addr;
    wire [IAW-1:0] o_sa  = (sel == 1) ? if3.store_addr : if1.store_addr;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int ph;
        int lyr;
        int nrn;
        int k;
        int w;
        bit ack;
        bit mac;
    } ent_t;

    ent_t trace[$];
    int   fin_q[$];
    int   dly[8];
    int   done_idx;
    int   l1_fetch;

    function automatic void push(input int ph, input int l, input int n, input int k, input int w,
                                 input bit ack);
        ent_t e;
        e.ph = ph; e.lyr = l; e.nrn = n; e.k = k; e.w = w; e.ack = ack; e.mac = 1'b0;
        trace.push_back(e);
    endfunction

    // One entry per clock after the start edge; mac strobes are the fetch cycles shifted by rdlat.
    task automatic build(input int rdlat);
        int w;
        int nrn;
        int fi;
        int fo;
        w = 0;
        nrn = 0;
        trace.delete();
        fin_q.delete();
        l1_fetch = -1;
        for (int l = 0; l <= HL; l++) begin
            fi = (l == 0) ? NIL : NHL;
            fo = (l == HL) ? NOL : NHL;
            for (int n = 0; n < fo; n++) begin
                push(P_CLR, l, n, 0, w, 1'b0);
                for (int k = 0; k < fi; k++) begin
                    if (l == 1 && l1_fetch < 0) l1_fetch = trace.size();
                    push(P_FETCH, l, n, k, w, 1'b0);
                    w++;
                end
                for (int d = 0; d < rdlat; d++) push(P_DRAIN, l, n, 0, w, 1'b0);
                push(P_RESC, l, n, 0, w, 1'b0);
                push(P_ACT, l, n, 0, w, 1'b0);
                for (int d = 0; d <= dly[nrn]; d++) push(P_STORE, l, n, 0, w, d == dly[nrn]);
                fin_q.push_back(fi);
                nrn++;
            end
        end
        done_idx = trace.size();
        push(P_DONE, 0, 0, 0, 0, 1'b0);
        push(P_IDLE, 0, 0, 0, 0, 1'b0);
        for (int t = rdlat; t < trace.size(); t++) trace[t].mac = (trace[t-rdlat].ph == P_FETCH);
    endtask

    function automatic logic [6:0] ctl_of(input ent_t e);
        return {e.ph >= P_CLR && e.ph <= P_STORE, e.ph == P_DONE, e.ph == P_CLR, e.mac,
                e.ph == P_RESC, e.ph == P_ACT, e.ph == P_STORE};
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, 32'(o_ctl), 32'd0);
        chk({tag, "_lyr"}, 32'(o_lyr), 32'd0);
        chk({tag, "_ia"},  32'(o_ia),  32'd0);
        chk({tag, "_wa"},  32'(o_wa),  32'd0);
        chk({tag, "_sa"},  32'(o_sa),  32'd0);
    endtask

    task automatic run(input int s, input int rdlat, input bit noisy, input int abort_at,
                       input int exp_lat);
        int   done_at;
        int   macs;
        int   nidx;
        ent_t e;
        done_at = -1;
        macs = 0;
        nidx = 0;
        sel = s;
        build(rdlat);
        @(negedge clk);
        start_r = 1'b1;
        ack_r   = 1'b0;
        for (int t = 0; t < trace.size(); t++) begin
            @(negedge clk);
            e = trace[t];
            if (t == abort_at) begin
                start_r = 1'b0;
                ack_r   = 1'b0;
                rst_n   = 1'b0;
                #1;
                chk_zero($sformatf("abort@%0d", t));
                chk("abort_nodone", 32'(done_at), 32'(-1));
                @(negedge clk);
                chk_zero("abort_hold");
                rst_n = 1'b1;
                return;
            end
            start_r = noisy && (e.ph != P_IDLE) && ($urandom_range(0, 3) == 0);
            ack_r   = e.ack;
            chk($sformatf("ctl@%0d", t), 32'(o_ctl), 32'(ctl_of(e)));
            if (e.ph != P_DONE && e.ph != P_IDLE)
                chk($sformatf("lyr@%0d", t), 32'(o_lyr), 32'({e.lyr == HL, e.lyr[0]}));
            if (e.ph == P_FETCH) begin
                chk($sformatf("ia@%0d", t), 32'(o_ia), 32'(e.k));
                chk($sformatf("wa@%0d", t), 32'(o_wa), 32'(e.w));
            end
            if (e.ph == P_STORE) chk($sformatf("sa@%0d", t), 32'(o_sa), 32'(e.nrn));
            if (o_ctl[3]) macs++;
            if (o_ctl[0] && ack_r) begin
                chk($sformatf("macs_n%0d", nidx), 32'(macs), 32'((nidx < fin_q.size()) ? fin_q[nidx] : -1));
                nidx++;
                macs = 0;
            end
            if (o_ctl[5] && done_at < 0) done_at = t;
        end
        start_r = 1'b0;
        ack_r   = 1'b0;
        chk("lat", 32'(done_at), 32'((exp_lat < 0) ? done_idx : exp_lat));
        chk("stores", 32'(nidx), 32'(fin_q.size()));
    endtask

    initial begin
        int ab;
        int rl;
        repeat (3) @(negedge clk);
        sel = 0;
        chk_zero("rst0");
        sel = 1;
        chk_zero("rst1");
        rst_n = 1'b1;

        dly = '{default: 0};
        run(0, 1, 1'b0, -1, 67);
        dly = '{0, 3, 0, 0, 0, 0, 0, 0};
        run(0, 1, 1'b0, -1, 70);

        dly = '{default: 0};
        build(1);
        ab = l1_fetch + 1;
        run(0, 1, 1'b0, ab, -1);
        run(0, 1, 1'b0, -1, 67);
        run(0, 1, 1'b1, -1, 67);
        run(1, 3, 1'b0, -1, 83);

        for (int i = 0; i < 6; i++) begin
            foreach (dly[j]) dly[j] = $urandom_range(0, 3);
            rl = (i % 2 == 1) ? 3 : 1;
            run(i % 2, rl, 1'b1, -1, -1);
        end

        foreach (dly[j]) dly[j] = $urandom_range(0, 2);
        build(3);
        ab = $urandom_range(1, done_idx - 1);
        run(1, 3, 1'b1, ab, -1);
        run(1, 3, 1'b1, -1, -1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/layer_sched.md
Name: layer_sched

Overview:
- Sequences the shared MAC/rescale/activation datapath through every neuron of every layer of the MLP: input, NO_HL hidden layers, output.
- Generates activation-buffer read addresses, linear weight-memory read addresses, MAC/rescale/activation strobes and result-store requests.
- Sits between the top-level start/done handshake and the datapath. Replaces hard-coded counter thresholds with nested layer/neuron/input counters.

Parameters:
- NO_HL, 2, number of hidden layers (≥1)
- NO_NIL, 784, input-layer width (fan-in of layer 0)
- NO_NHL, 28, neurons per hidden layer
- NO_NOL, 10, output neurons
- RD_LAT, 1, weight/activation memory read latency in cycles (1..3)
- WAW, clog2(NO_NIL*NO_NHL + (NO_HL-1)*NO_NHL*NO_NHL + NO_NHL*NO_NOL), weight address width (localparam)
- IAW, clog2(max(NO_NIL,NO_NHL)), input address width (localparam)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; begins inference when idle
- store_ack  in  1  activation buffer accepted store_en write
- in_addr  out  IAW  read address into current source buffer
- in_sel  out  1  source buffer: 0 = image buffer, 1/0 ping-pong hidden buffers thereafter (toggles per layer ≥1)
- w_addr  out  WAW  weight memory read address
- mac_clr  out  1  clear accumulator
- mac_en  out  1  accumulate current read data
- rescale  out  1  rescale accumulator
- act_en  out  1  apply activation
- store_en  out  1  write activated result
- store_addr  out  IAW  destination neuron index
- last_layer  out  1  current layer is the output layer (selects linear/argmax path)
- busy  out  1  high from start accept until done
- done  out  1  one-cycle pulse at completion

Behaviour:
- Reset (async on rst_n low): state IDLE; all counters, addresses and strobes 0; busy=0, done=0. Reset mid-inference aborts immediately; no partial done.
- Layer L (0..NO_HL): fan_in = NO_NIL for L=0, else NO_NHL; fan_out = NO_NOL for L=NO_HL, else NO_NHL.
- States:
  - IDLE: start=1 → CLR, busy=1. start is ignored when not IDLE.
  - CLR: mac_clr=1 for 1 cycle; input counter k=0 → FETCH.
  - FETCH: in_addr=k, w_addr increments each cycle; k=fan_in-1 → DRAIN.
  - DRAIN: RD_LAT cycles → RESCALE.
  - mac_en timing: registered copy of "FETCH active" delayed RD_LAT cycles, so exactly fan_in mac_en pulses per neuron, the first RD_LAT cycles after the first FETCH cycle.
  - RESCALE: rescale=1, 1 cycle → ACT.
  - ACT: act_en=1, 1 cycle → STORE.
  - STORE: store_en=1, store_addr=neuron index, held until store_ack (ack in same cycle allowed).
    - On ack, neuron<fan_out-1 → neuron+1, CLR.
    - Else L<NO_HL → L+1, neuron=0, toggle in_sel, CLR.
    - Else → DONE.
  - DONE: done=1, busy=0 → IDLE.
- Weight address:
  - w_addr is never reset between neurons/layers; it runs 0..total_weights-1 contiguously.
  - w_addr returns to 0 only in IDLE.
- in_sel: 0 for L=0; L=1 reads buffer 1; alternates thereafter. Writes go to the opposite buffer (datapath derives write buffer as ~in_sel, buffer 1 for L=0).
- Cycle count per neuron with immediate ack: fan_in + RD_LAT + 4.
- Strobes are one-hot; at most one of mac_clr/rescale/act_en/store_en high per cycle. mac_en may overlap only DRAIN.

Decomposition:
- Shared package nn_pkg: state encoding localparams, layer-size functions (fan_in(L), fan_out(L)), total-weight constant.
- One sub-module: sched_counter (parameterised wrap counter with terminal-count flag), used for k, neuron and layer.

Test Plan:
- Params NO_NIL=4, NO_NHL=3, NO_NOL=2, NO_HL=2, RD_LAT=1, store_ack tied 1; start pulse → done after exactly 67 cycles (27+24+16); 8 store_en pulses; last w_addr=26.
- Same config: count mac_en per neuron → 4,4,4,3,3,3,3,3. in_sel sequence per layer → 0,1,0. last_layer high only for final 2 neurons.
- store_ack delayed 3 cycles on neuron 1 → FSM holds STORE, store_en high 4 cycles, counters frozen; total done latency 70.
- rst_n asserted mid-FETCH of layer 1 → all outputs 0 immediately, no done; new start → full run of 67 cycles from w_addr=0.
- start pulsed again while busy → ignored, single done pulse, counts unchanged.
- RD_LAT=3 → each neuron 2 cycles longer; total 83 cycles; first mac_en 3 cycles after first FETCH.
